dshot_frame_sequencer: RTL

// - Drives one DShot output line from a 16-bit frame, owning the enable of a baudrate12MHz

---
 rtl/dshot_frame_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dshot_frame_sequencer.sv
// DShot output sequencer: accepts throttle commands, appends the CRC nibble and shifts
// the frame onto the line. Bit timing comes from an external baud generator.
module dshot_frame_sequencer #(
    parameter int GAP_BITS    = 16,
    parameter bit AUTO_REPEAT = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst,
    // valid/ready: a command transfers on a cycle where cmd_valid and cmd_ready are both
    // high; cmd_ready is high exactly when the single pending slot is empty.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [10:0] cmd_throttle,
    input  logic        cmd_telem,
    output logic        baud_enable,
    input  logic        baud_tick,
    input  logic        baud_half,
    input  logic        baud_quarter,
    output logic        dshot_out,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  dbg_state
);

    localparam int GAP_W = $clog2(GAP_BITS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic [15:0]        pend_frame_q, pend_frame_d;
    logic [15:0]        last_frame_q, last_frame_d;
    logic               sent_any_q, sent_any_d;
    logic [15:0]        shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               baud_en_q, baud_en_d;
    logic               dshot_q, dshot_d;
    logic               done_q, done_d;
    logic               accept;

    function automatic logic [15:0] build_frame(input logic [10:0] thr, input logic tel);
        logic [11:0] v;
        v = {thr, tel};
        return {v, v[3:0] ^ v[7:4] ^ v[11:8]};
    endfunction

    assign accept = cmd_valid && !pend_valid_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_frame_q <= '0;
            last_frame_q <= '0;
            sent_any_q   <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            baud_en_q    <= 1'b0;
            dshot_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_frame_q <= pend_frame_d;
            last_frame_q <= last_frame_d;
            sent_any_q   <= sent_any_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            baud_en_q    <= baud_en_d;
            dshot_q      <= dshot_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_frame_d = pend_frame_q;
        last_frame_d = last_frame_q;
        sent_any_d   = sent_any_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        baud_en_d    = baud_en_q;
        dshot_d      = 1'b0;
        done_d       = 1'b0;

        // Loads only happen with the slot full and accepts only with it empty, so they never collide.
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_frame_d = build_frame(cmd_throttle, cmd_telem);
        end

        case (state_q)
            IDLE: begin
                baud_en_d = 1'b0;
                if (pend_valid_q) begin
                    shift_d      = pend_frame_q;
                    last_frame_d = pend_frame_q;
                    bit_cnt_d    = 4'd15;
                    pend_valid_d = 1'b0;
                    sent_any_d   = 1'b1;
                    baud_en_d    = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                baud_en_d = 1'b1;
                // '1' stays high for three quarters of the period, '0' for the first quarter.
                dshot_d = shift_q[15] ? !(baud_half && baud_quarter)
                                      : (!baud_half && !baud_quarter);
                if (baud_tick) begin
                    if (bit_cnt_q == 4'd0) begin
                        done_d    = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            GAP: begin
                baud_en_d = 1'b1;
                if (baud_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        if (pend_valid_q) begin
                            shift_d      = pend_frame_q;
                            last_frame_d = pend_frame_q;
                            bit_cnt_d    = 4'd15;
                            pend_valid_d = 1'b0;
                            sent_any_d   = 1'b1;
                            state_d      = SEND;
                        end else if (AUTO_REPEAT && sent_any_q) begin
                            shift_d   = last_frame_q;
                            bit_cnt_d = 4'd15;
                            state_d   = SEND;
                        end else begin
                            baud_en_d = 1'b0;
                            state_d   = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                baud_en_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign cmd_ready   = !pend_valid_q;
    assign busy        = (state_q != IDLE);
    assign baud_enable = baud_en_q;
    assign dshot_out   = dshot_q;
    assign frame_done  = done_q;
    assign dbg_state   = state_q;

endmodule
